// File: rtl/reg_decode_wb_if.sv
// Decode/write-back bus between the SEQ controller and reg_decode_wb.
// Carries instruction fields and write-back data in, and decoded ids, operands and status out.
interface reg_decode_wb_if #(
  parameter int DATA_W = 64
);
  logic              wb_en;
  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              cnd;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [3:0]        dstE;
  logic [3:0]        dstM;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              halted;
  logic              instr_err;

  modport master (
    output wb_en, icode, rA, rB, cnd, valE, valM, dbg_addr,
    input  srcA, srcB, dstE, dstM, valA, valB, dbg_data, halted, instr_err
  );

  modport slave (
    input  wb_en, icode, rA, rB, cnd, valE, valM, dbg_addr,
    output srcA, srcB, dstE, dstM, valA, valB, dbg_data, halted, instr_err
  );
endinterface

// File: rtl/reg_decode_wb.sv
// SEQ Y86-64 decode/write-back: zero-latency combinational decode and reads, commit on the wb_en edge.
// No backpressure: one commit per wb_en pulse; sticky halt/invalid status freezes all further commits.
module reg_decode_wb #(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic           clk,
  input  logic           reset,
  reg_decode_wb_if.slave bus
);
  localparam logic [3:0] RSP  = 4'h4;
  localparam logic [3:0] NONE = 4'hF;

  logic [DATA_W-1:0] regs [0:14];
  logic              halted;
  logic              instr_err;
  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic              commit;

  always_comb begin
    src_a = NONE;
    src_b = NONE;
    dst_e = NONE;
    dst_m = NONE;
    case (bus.icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = bus.rA;
      4'h9, 4'hB:             src_a = RSP;
      default:                src_a = NONE;
    endcase
    case (bus.icode)
      4'h4, 4'h5, 4'h6:       src_b = bus.rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
      default:                src_b = NONE;
    endcase
    case (bus.icode)
      4'h2:                   dst_e = bus.cnd ? bus.rB : NONE;
      4'h3, 4'h6:             dst_e = bus.rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = RSP;
      default:                dst_e = NONE;
    endcase
    case (bus.icode)
      4'h5, 4'hB:             dst_m = bus.rA;
      default:                dst_m = NONE;
    endcase
  end

  assign bus.srcA = src_a;
  assign bus.srcB = src_b;
  assign bus.dstE = dst_e;
  assign bus.dstM = dst_m;

  // Register F does not exist; any read of it returns zero.
  assign bus.valA     = (src_a == NONE)        ? '0 : regs[src_a];
  assign bus.valB     = (src_b == NONE)        ? '0 : regs[src_b];
  assign bus.dbg_data = (bus.dbg_addr == NONE) ? '0 : regs[bus.dbg_addr];

  assign bus.halted    = halted;
  assign bus.instr_err = instr_err;

  assign commit = bus.wb_en && !halted && !instr_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == 4) ? RSP_INIT : '0;
      end
      halted    <= 1'b0;
      instr_err <= 1'b0;
    end else if (commit) begin
      if (bus.icode == 4'h0) begin
        halted <= 1'b1;
      end else if (bus.icode > 4'hB) begin
        instr_err <= 1'b1;
      end else begin
        // On a dstE/dstM collision (popq %rsp) only the memory value is written.
        if (dst_e != NONE && dst_e != dst_m) begin
          regs[dst_e] <= bus.valE;
        end
        if (dst_m != NONE) begin
          regs[dst_m] <= bus.valM;
        end
      end
    end
  end
endmodule
